// File: rtl/decode_forward_scoreboard_if.sv
// Decode-side bus of the forwarding scoreboard: decode slot, register file data,
// stage result buses in; forwarded operands, bypass selects and load-use stall out.
interface decode_forward_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_READ   = 2,
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 16
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    logic                             id_valid;
    logic [REG_ADDR_W-1:0]            id_rd;
    logic                             id_rd_we;
    logic                             id_is_load;
    logic [NUM_READ*REG_ADDR_W-1:0]   id_rs;
    logic [NUM_READ*DATA_WIDTH-1:0]   rf_data;
    logic [NUM_STAGES*DATA_WIDTH-1:0] stage_result;
    logic                             flush;
    logic                             cnt_clear;
    logic [NUM_READ*DATA_WIDTH-1:0]   operand;
    logic [NUM_READ*SEL_W-1:0]        bypass_sel;
    logic                             stall;
    logic [CNT_W-1:0]                 stall_count;

    modport master (
        output id_valid, id_rd, id_rd_we, id_is_load, id_rs,
               rf_data, stage_result, flush, cnt_clear,
        input  operand, bypass_sel, stall, stall_count
    );

    modport slave (
        input  id_valid, id_rd, id_rd_we, id_is_load, id_rs,
               rf_data, stage_result, flush, cnt_clear,
        output operand, bypass_sel, stall, stall_count
    );
endinterface

// File: rtl/decode_forward_scoreboard.sv
// Decode-stage operand forwarding with an internal in-flight write scoreboard.
// The youngest matching producer wins; an unready load producer raises stall.
module decode_forward_scoreboard #(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_W       = 5,
    parameter int NUM_READ         = 2,
    parameter int NUM_STAGES       = 3,
    parameter int LOAD_READY_STAGE = 1,
    parameter int CNT_W            = 16
) (
    input logic                      clock,
    input logic                      reset_n,
    decode_forward_scoreboard_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    logic [NUM_STAGES-1:0]          r_v;
    logic [NUM_STAGES-1:0]          r_ld;
    logic [REG_ADDR_W-1:0]          r_rd [NUM_STAGES];
    logic [CNT_W-1:0]               r_stall_count;

    logic [REG_ADDR_W-1:0]          w_rs     [NUM_READ];
    logic [SEL_W-1:0]               w_sel    [NUM_READ];
    logic [DATA_WIDTH-1:0]          w_op     [NUM_READ];
    logic [NUM_READ-1:0]            w_ld_hit;
    logic [NUM_READ*DATA_WIDTH-1:0] w_operand;
    logic [NUM_READ*SEL_W-1:0]      w_bypass_sel;
    logic                           w_stall;
    logic                           w_enter;

    always_comb begin
        for (int p = 0; p < NUM_READ; p++) begin
            w_rs[p] = bus.id_rs[p*REG_ADDR_W +: REG_ADDR_W];
        end
    end

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        for (int p = 0; p < NUM_READ; p++) begin
            w_sel[p]    = '0;
            w_op[p]     = bus.rf_data[p*DATA_WIDTH +: DATA_WIDTH];
            w_ld_hit[p] = 1'b0;
            if (w_rs[p] == '0) begin
                w_op[p] = '0;
            end else begin
                for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                    if (r_v[s] && (r_rd[s] == w_rs[p])) begin
                        w_sel[p]    = SEL_W'(s + 1);
                        w_op[p]     = bus.stage_result[s*DATA_WIDTH +: DATA_WIDTH];
                        w_ld_hit[p] = r_ld[s] && (s < LOAD_READY_STAGE);
                    end
                end
            end
        end
    end

    always_comb begin
        w_operand    = '0;
        w_bypass_sel = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            w_operand[p*DATA_WIDTH +: DATA_WIDTH] = w_op[p];
            w_bypass_sel[p*SEL_W +: SEL_W]        = w_sel[p];
        end
    end

    // Flush dominates: a squashed instruction never stalls.
    assign w_stall = bus.id_valid && !bus.flush && (|w_ld_hit);
    assign w_enter = bus.id_valid && bus.id_rd_we && (bus.id_rd != '0)
                     && !w_stall && !bus.flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v  <= '0;
            r_ld <= '0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                r_rd[s] <= '0;
            end
        end else begin
            r_v[0]  <= w_enter;
            r_rd[0] <= bus.id_rd;
            r_ld[0] <= bus.id_is_load;
            for (int s = 1; s < NUM_STAGES; s++) begin
                r_v[s]  <= r_v[s-1];
                r_rd[s] <= r_rd[s-1];
                r_ld[s] <= r_ld[s-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_count <= '0;
        end else if (bus.cnt_clear) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign bus.operand     = w_operand;
    assign bus.bypass_sel  = w_bypass_sel;
    assign bus.stall       = w_stall;
    assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_decode_forward_scoreboard.sv
// Bench for decode_forward_scoreboard: directed scenarios plus randomized traffic
// checked against a queue-based model of in-flight writers.
module tb_decode_forward_scoreboard;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NR  = 2;
    localparam int NS  = 3;
    localparam int LRS = 1;
    localparam int CW  = 8;
    localparam int SW  = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    decode_forward_scoreboard_if #(.DATA_WIDTH(DW), .REG_ADDR_W(AW), .NUM_READ(NR),
        .NUM_STAGES(NS), .CNT_W(CW)) ifc ();

    decode_forward_scoreboard #(.DATA_WIDTH(DW), .REG_ADDR_W(AW), .NUM_READ(NR),
        .NUM_STAGES(NS), .LOAD_READY_STAGE(LRS), .CNT_W(CW)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (ifc.slave)
    );

    typedef struct {
        bit           v;
        bit [AW-1:0]  rd;
        bit           ld;
    } ent_t;

    ent_t            pipe[$];
    int unsigned     m_cnt;
    logic [NR*DW-1:0] e_op;
    logic [NR*SW-1:0] e_sel;
    bit              e_stall;
    int              n_tests = 0;
    int              n_fail  = 0;

    function automatic void model_reset();
        pipe.delete();
        for (int i = 0; i < NS; i++) pipe.push_back('{v: 1'b0, rd: '0, ld: 1'b0});
        m_cnt = 0;
    endfunction

    // Youngest writer is at the front of the queue.
    function automatic void model_eval();
        bit hz;
        bit found;
        logic [AW-1:0] rs;
        logic [DW-1:0] op;
        int sel;
        hz = 0;
        e_op = '0;
        e_sel = '0;
        for (int p = 0; p < NR; p++) begin
            rs = ifc.id_rs[p*AW +: AW];
            op = ifc.rf_data[p*DW +: DW];
            sel = 0;
            found = 0;
            if (rs == 0) op = '0;
            else begin
                for (int i = 0; i < pipe.size(); i++) begin
                    if (!found && pipe[i].v && pipe[i].rd == rs) begin
                        found = 1;
                        sel = i + 1;
                        op = ifc.stage_result[i*DW +: DW];
                        if (pipe[i].ld && i < LRS) hz = 1;
                    end
                end
            end
            e_op[p*DW +: DW] = op;
            e_sel[p*SW +: SW] = sel[SW-1:0];
        end
        e_stall = ifc.id_valid && !ifc.flush && hz;
    endfunction

    task automatic tick();
        ent_t e;
        model_eval();
        e.v  = ifc.id_valid && ifc.id_rd_we && (ifc.id_rd != 0) && !e_stall && !ifc.flush;
        e.rd = ifc.id_rd;
        e.ld = ifc.id_is_load;
        pipe.push_front(e);
        void'(pipe.pop_back());
        if (ifc.cnt_clear) m_cnt = 0;
        else if (e_stall && m_cnt != CMAX) m_cnt++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        ifc.id_valid     = 1'b0;
        ifc.id_rd        = '0;
        ifc.id_rd_we     = 1'b0;
        ifc.id_is_load   = 1'b0;
        ifc.id_rs        = '0;
        ifc.flush        = 1'b0;
        ifc.cnt_clear    = 1'b0;
        ifc.rf_data      = {$urandom, $urandom};
        ifc.stage_result = {$urandom, $urandom, $urandom};
    endtask

    task automatic issue(input logic [AW-1:0] rd, input logic ld);
        ifc.id_valid   = 1'b1;
        ifc.id_rd      = rd;
        ifc.id_rd_we   = 1'b1;
        ifc.id_is_load = ld;
        ifc.id_rs      = '0;
        tick();
    endtask

    task automatic drain();
        idle();
        repeat (NS) tick();
    endtask

    task automatic test_reset();
        idle();
        ifc.rf_data = {32'h22, 32'h11};
        ifc.id_rs   = {5'd2, 5'd1};
        model_reset();
        #12;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        n_tests++; if (ifc.operand !== {32'h22, 32'h11}) begin n_fail++;
            $display("FAIL reset_operand: got %h expected %h", ifc.operand, {32'h22, 32'h11}); end
        n_tests++; if (ifc.bypass_sel !== 4'd0) begin n_fail++;
            $display("FAIL reset_sel: got %h expected 0", ifc.bypass_sel); end
        n_tests++; if (ifc.stall !== 1'b0) begin n_fail++;
            $display("FAIL reset_stall: got %b expected 0", ifc.stall); end
        n_tests++; if (ifc.stall_count !== 8'd0) begin n_fail++;
            $display("FAIL reset_count: got %h expected 0", ifc.stall_count); end
    endtask

    task automatic test_alu_chain();
        drain();
        issue(5'd5, 1'b0);
        idle();
        ifc.id_rs = {5'd0, 5'd5};
        ifc.stage_result[31:0] = 32'hAAAA0001;
        #1;
        n_tests++; if (ifc.bypass_sel[1:0] !== 2'd1 || ifc.operand[31:0] !== 32'hAAAA0001) begin n_fail++;
            $display("FAIL alu_stage0: got sel %0d op %h expected sel 1 op aaaa0001",
                     ifc.bypass_sel[1:0], ifc.operand[31:0]); end
        tick();
        n_tests++; if (ifc.bypass_sel[1:0] !== 2'd2 || ifc.operand[31:0] !== ifc.stage_result[63:32]) begin n_fail++;
            $display("FAIL alu_stage1: got sel %0d op %h expected sel 2 op %h",
                     ifc.bypass_sel[1:0], ifc.operand[31:0], ifc.stage_result[63:32]); end
        tick();
        n_tests++; if (ifc.bypass_sel[1:0] !== 2'd3 || ifc.operand[31:0] !== ifc.stage_result[95:64]) begin n_fail++;
            $display("FAIL alu_stage2: got sel %0d op %h expected sel 3 op %h",
                     ifc.bypass_sel[1:0], ifc.operand[31:0], ifc.stage_result[95:64]); end
        tick();
        n_tests++; if (ifc.bypass_sel[1:0] !== 2'd0 || ifc.operand[31:0] !== ifc.rf_data[31:0]) begin n_fail++;
            $display("FAIL alu_retired: got sel %0d op %h expected sel 0 op %h",
                     ifc.bypass_sel[1:0], ifc.operand[31:0], ifc.rf_data[31:0]); end
    endtask

    task automatic test_load_use();
        drain();
        issue(5'd7, 1'b1);
        ifc.id_rd = 5'd9;
        ifc.id_is_load = 1'b0;
        ifc.id_rs = {5'd7, 5'd0};
        #1;
        n_tests++; if (ifc.stall !== 1'b1 || ifc.bypass_sel[3:2] !== 2'd1) begin n_fail++;
            $display("FAIL load_use_stall: got stall %b sel1 %0d expected stall 1 sel1 1",
                     ifc.stall, ifc.bypass_sel[3:2]); end
        tick();
        n_tests++; if (ifc.stall !== 1'b0 || ifc.bypass_sel[3:2] !== 2'd2) begin n_fail++;
            $display("FAIL load_use_release: got stall %b sel1 %0d expected stall 0 sel1 2",
                     ifc.stall, ifc.bypass_sel[3:2]); end
        n_tests++; if (ifc.operand[63:32] !== ifc.stage_result[63:32]) begin n_fail++;
            $display("FAIL load_use_operand: got %h expected %h", ifc.operand[63:32], ifc.stage_result[63:32]); end
        n_tests++; if (ifc.stall_count !== 8'd1) begin n_fail++;
            $display("FAIL load_use_count: got %0d expected 1", ifc.stall_count); end
        tick();
    endtask

    task automatic test_shadow_x0();
        drain();
        issue(5'd3, 1'b0);
        issue(5'd8, 1'b0);
        issue(5'd3, 1'b0);
        ifc.id_rd = 5'd0;
        ifc.rf_data = {32'hDEAD0001, 32'hBEEF0002};
        ifc.id_rs = {5'd0, 5'd3};
        #1;
        n_tests++; if (ifc.bypass_sel[1:0] !== 2'd1 || ifc.operand[31:0] !== ifc.stage_result[31:0]) begin n_fail++;
            $display("FAIL shadow_youngest: got sel %0d op %h expected sel 1 op %h",
                     ifc.bypass_sel[1:0], ifc.operand[31:0], ifc.stage_result[31:0]); end
        n_tests++; if (ifc.bypass_sel[3:2] !== 2'd0 || ifc.operand[63:32] !== 32'h0) begin n_fail++;
            $display("FAIL x0_operand: got sel %0d op %h expected sel 0 op 0",
                     ifc.bypass_sel[3:2], ifc.operand[63:32]); end
        tick();
        idle();
        ifc.id_rs = {5'd0, 5'd3};
        #1;
        n_tests++; if (ifc.bypass_sel[1:0] !== 2'd2) begin n_fail++;
            $display("FAIL shadow_after_x0: got sel %0d expected 2", ifc.bypass_sel[1:0]); end
    endtask

    task automatic test_flush();
        drain();
        issue(5'd4, 1'b1);
        ifc.id_rd = 5'd6;
        ifc.id_is_load = 1'b0;
        ifc.id_rs = {5'd0, 5'd4};
        ifc.flush = 1'b1;
        #1;
        n_tests++; if (ifc.stall !== 1'b0 || ifc.bypass_sel[1:0] !== 2'd1) begin n_fail++;
            $display("FAIL flush_no_stall: got stall %b sel0 %0d expected stall 0 sel0 1",
                     ifc.stall, ifc.bypass_sel[1:0]); end
        tick();
        idle();
        ifc.id_rs = {5'd4, 5'd6};
        #1;
        n_tests++; if (ifc.bypass_sel !== 4'b1000 || ifc.stall !== 1'b0) begin n_fail++;
            $display("FAIL flush_bubble: got sel %b stall %b expected sel 1000 stall 0",
                     ifc.bypass_sel, ifc.stall); end
    endtask

    task automatic test_saturation();
        drain();
        ifc.id_valid = 1'b1;
        ifc.id_rd_we = 1'b1;
        ifc.id_is_load = 1'b1;
        ifc.id_rd = 5'd7;
        ifc.id_rs = {5'd7, 5'd0};
        for (int i = 0; i < 600; i++) begin
            #1;
            model_eval();
            n_tests++; if (ifc.stall !== e_stall || ifc.stall_count !== m_cnt[CW-1:0]) begin n_fail++;
                $display("FAIL sat_cycle%0d: got stall %b count %0d expected stall %b count %0d",
                         i, ifc.stall, ifc.stall_count, e_stall, m_cnt); end
            tick();
        end
        n_tests++; if (ifc.stall_count !== 8'hFF) begin n_fail++;
            $display("FAIL sat_value: got %h expected ff", ifc.stall_count); end
        for (int i = 0; i < 4; i++) begin
            model_eval();
            if (e_stall) break;
            tick();
        end
        ifc.cnt_clear = 1'b1;
        #1;
        n_tests++; if (ifc.stall !== 1'b1) begin n_fail++;
            $display("FAIL clear_setup_stall: got %b expected 1", ifc.stall); end
        tick();
        ifc.cnt_clear = 1'b0;
        n_tests++; if (ifc.stall_count !== 8'd0) begin n_fail++;
            $display("FAIL clear_priority: got %0d expected 0", ifc.stall_count); end
    endtask

    task automatic test_async_reset();
        drain();
        issue(5'd10, 1'b0);
        issue(5'd11, 1'b0);
        issue(5'd12, 1'b1);
        ifc.id_valid = 1'b1;
        ifc.id_rd_we = 1'b0;
        ifc.id_is_load = 1'b0;
        ifc.id_rs = {5'd12, 5'd10};
        tick();
        idle();
        ifc.id_rs = {5'd12, 5'd11};
        #1;
        n_tests++; if (ifc.bypass_sel !== 4'b1011 || ifc.stall_count === 8'd0) begin n_fail++;
            $display("FAIL areset_setup: got sel %b count %0d expected sel 1011 count nonzero",
                     ifc.bypass_sel, ifc.stall_count); end
        #1;
        reset_n = 1'b0;
        #1;
        n_tests++; if (ifc.bypass_sel !== 4'd0 || ifc.stall !== 1'b0) begin n_fail++;
            $display("FAIL areset_immediate: got sel %b stall %b expected 0 0", ifc.bypass_sel, ifc.stall); end
        n_tests++; if (ifc.operand !== ifc.rf_data || ifc.stall_count !== 8'd0) begin n_fail++;
            $display("FAIL areset_operand: got op %h count %0d expected op %h count 0",
                     ifc.operand, ifc.stall_count, ifc.rf_data); end
        model_reset();
        reset_n = 1'b1;
        tick();
        n_tests++; if (ifc.bypass_sel !== 4'd0 || ifc.operand !== ifc.rf_data) begin n_fail++;
            $display("FAIL areset_next_cycle: got sel %b op %h expected sel 0 op %h",
                     ifc.bypass_sel, ifc.operand, ifc.rf_data); end
    endtask

    task automatic test_random();
        drain();
        for (int i = 0; i < 400; i++) begin
            ifc.id_valid     = ($urandom_range(0, 3) != 0);
            ifc.id_rd        = AW'($urandom_range(0, 7));
            ifc.id_rd_we     = ($urandom_range(0, 3) != 0);
            ifc.id_is_load   = ($urandom_range(0, 2) == 0);
            ifc.id_rs        = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            ifc.flush        = ($urandom_range(0, 9) == 0);
            ifc.cnt_clear    = ($urandom_range(0, 31) == 0);
            ifc.rf_data      = {$urandom, $urandom};
            ifc.stage_result = {$urandom, $urandom, $urandom};
            #1;
            model_eval();
            n_tests++; if (ifc.operand !== e_op) begin n_fail++;
                $display("FAIL rand_operand%0d: got %h expected %h", i, ifc.operand, e_op); end
            n_tests++; if (ifc.bypass_sel !== e_sel) begin n_fail++;
                $display("FAIL rand_sel%0d: got %b expected %b", i, ifc.bypass_sel, e_sel); end
            n_tests++; if (ifc.stall !== e_stall) begin n_fail++;
                $display("FAIL rand_stall%0d: got %b expected %b", i, ifc.stall, e_stall); end
            n_tests++; if (ifc.stall_count !== m_cnt[CW-1:0]) begin n_fail++;
                $display("FAIL rand_count%0d: got %0d expected %0d", i, ifc.stall_count, m_cnt); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_shadow_x0();
        test_flush();
        test_saturation();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, got no end expected end");
        $fatal(1);
    end

endmodule
